// File: rtl/shelf_nav_ctrl.sv
// Line-following shelf robot controller: seeks the target aisle junction, turns in,
// stops at the target slot for a fixed dwell, then follows the line back home.
module shelf_nav_ctrl #(
    parameter int unsigned AISLES       = 3,
    parameter int unsigned SLOTS        = 3,
    parameter int unsigned DWELL_CYCLES = 250000000,
    parameter int unsigned TURN_CYCLES  = 50000000,
    parameter int unsigned AW           = (AISLES > 1) ? $clog2(AISLES) : 1,
    parameter int unsigned SW           = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_aisle,
    input  logic [SW-1:0] cmd_slot,
    input  logic          abort,
    input  logic          pos_valid,
    input  logic [1:0]    pos_kind,
    input  logic [AW-1:0] pos_aisle,
    input  logic [SW-1:0] pos_slot,
    input  logic          lt1,
    input  logic          lt2,
    input  logic          lt3,
    output logic          m1,
    output logic          m2,
    output logic          m3,
    output logic          m4,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSeek   = 3'd1,
        StTurn   = 3'd2,
        StAisle  = 3'd3,
        StDwell  = 3'd4,
        StReturn = 3'd5
    } state_e;

    localparam logic [3:0] MotStop  = 4'b1111;
    localparam logic [3:0] MotFwd   = 4'b1001;
    localparam logic [3:0] MotRight = 4'b0101;
    localparam logic [3:0] MotLeft  = 4'b1010;

    localparam logic [1:0] KindJunction = 2'b00;
    localparam logic [1:0] KindSlot     = 2'b01;
    localparam logic [1:0] KindHome     = 2'b11;

    localparam int unsigned MaxCycles = (DWELL_CYCLES > TURN_CYCLES) ? DWELL_CYCLES : TURN_CYCLES;
    localparam int unsigned CW        = $clog2(MaxCycles + 1);

    localparam logic [CW-1:0] TurnLast  = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] DwellLast = CW'(DWELL_CYCLES - 1);
    localparam logic [AW:0]   AisleLim  = AISLES[AW:0];
    localparam logic [SW:0]   SlotLim   = SLOTS[SW:0];

    state_e        state_q;
    logic [3:0]    motor_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          cmd_ready_q;
    logic [CW-1:0] turn_cnt_q;
    logic [CW-1:0] dwell_cnt_q;
    logic [AW-1:0] tgt_aisle_q;
    logic [SW-1:0] tgt_slot_q;

    logic cmd_in_range;
    logic junction_hit;
    logic slot_hit;
    logic home_hit;
    logic [3:0] follow_mot;

    assign cmd_in_range = ({1'b0, cmd_aisle} < AisleLim) && ({1'b0, cmd_slot} < SlotLim);
    assign junction_hit = pos_valid && (pos_kind == KindJunction) && (pos_aisle == tgt_aisle_q);
    assign slot_hit     = pos_valid && (pos_kind == KindSlot) && (pos_aisle == tgt_aisle_q) &&
                          (pos_slot == tgt_slot_q);
    assign home_hit     = pos_valid && (pos_kind == KindHome);

    // Centre sensor has priority, then right, then left.
    always_comb begin
        follow_mot = MotStop;
        if (lt2) begin
            follow_mot = MotFwd;
        end else if (lt1) begin
            follow_mot = MotRight;
        end else if (lt3) begin
            follow_mot = MotLeft;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            motor_q     <= MotStop;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            turn_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            tgt_aisle_q <= '0;
            tgt_slot_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    motor_q     <= MotStop;
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        tgt_aisle_q <= cmd_aisle;
                        tgt_slot_q  <= cmd_slot;
                        if (cmd_in_range) begin
                            state_q     <= StSeek;
                            busy_q      <= 1'b1;
                            cmd_ready_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StSeek: begin
                    motor_q <= follow_mot;
                    if (abort) begin
                        state_q <= StReturn;
                    end else if (junction_hit) begin
                        state_q    <= StTurn;
                        turn_cnt_q <= '0;
                    end
                end
                StTurn: begin
                    motor_q <= MotLeft;
                    if (abort) begin
                        state_q <= StReturn;
                    end else if (turn_cnt_q == TurnLast) begin
                        state_q <= StAisle;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + 1'b1;
                    end
                end
                StAisle: begin
                    motor_q <= follow_mot;
                    if (abort) begin
                        state_q <= StReturn;
                    end else if (slot_hit) begin
                        state_q     <= StDwell;
                        dwell_cnt_q <= '0;
                    end
                end
                StDwell: begin
                    motor_q <= MotStop;
                    if (abort) begin
                        state_q <= StReturn;
                    end else if (dwell_cnt_q == DwellLast) begin
                        state_q <= StReturn;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end
                StReturn: begin
                    motor_q <= follow_mot;
                    if (home_hit) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    // Unused encodings recover to IDLE.
                    state_q     <= StIdle;
                    motor_q     <= MotStop;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign {m1, m2, m3, m4} = motor_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = cmd_ready_q;
    assign state     = state_q;

endmodule

// File: tb/tb_shelf_nav_ctrl.sv
// Directed bench for shelf_nav_ctrl: a vector table for line-follow and tag filtering
// in SEEK, plus hand-written job, abort, error and reset sequences.
module tb_shelf_nav_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_aisle;
    logic [1:0] cmd_slot;
    logic       abort;
    logic       pos_valid;
    logic [1:0] pos_kind;
    logic [1:0] pos_aisle;
    logic [1:0] pos_slot;
    logic       lt1, lt2, lt3;
    logic       m1, m2, m3, m4;
    logic       busy, done, err;
    logic [2:0] state;
    logic [3:0] mot;

    assign mot = {m1, m2, m3, m4};

    shelf_nav_ctrl #(
        .AISLES      (3),
        .SLOTS       (3),
        .DWELL_CYCLES(10),
        .TURN_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_aisle(cmd_aisle),
        .cmd_slot (cmd_slot),
        .abort    (abort),
        .pos_valid(pos_valid),
        .pos_kind (pos_kind),
        .pos_aisle(pos_aisle),
        .pos_slot (pos_slot),
        .lt1      (lt1),
        .lt2      (lt2),
        .lt3      (lt3),
        .m1       (m1),
        .m2       (m2),
        .m3       (m3),
        .m4       (m4),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] STOP  = 4'b1111;
    localparam logic [3:0] FWD   = 4'b1001;
    localparam logic [3:0] RIGHT = 4'b0101;
    localparam logic [3:0] LEFT  = 4'b1010;

    typedef struct {
        logic [2:0] lt;     // {lt1, lt2, lt3}
        logic       pv;
        logic [1:0] kind;
        logic [1:0] aisle;
        logic [1:0] slot;
        logic [3:0] exp_mot;
        logic [2:0] exp_st;
    } vec_t;

    vec_t vecs[12];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lt(input logic [2:0] v);
        lt1 = v[2];
        lt2 = v[1];
        lt3 = v[0];
    endtask

    task automatic tag(input logic [1:0] kind, input logic [1:0] a, input logic [1:0] s);
        pos_valid = 1'b1;
        pos_kind  = kind;
        pos_aisle = a;
        pos_slot  = s;
        tick();
        pos_valid = 1'b0;
    endtask

    task automatic go(input logic [1:0] a, input logic [1:0] s);
        cmd_valid = 1'b1;
        cmd_aisle = a;
        cmd_slot  = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Target aisle 1, slot 2 while in SEEK.
        vecs[0]  = '{3'b010, 1'b0, 2'b00, 2'd0, 2'd0, FWD,   3'd1};
        vecs[1]  = '{3'b100, 1'b0, 2'b00, 2'd0, 2'd0, RIGHT, 3'd1};
        vecs[2]  = '{3'b001, 1'b0, 2'b00, 2'd0, 2'd0, LEFT,  3'd1};
        vecs[3]  = '{3'b111, 1'b0, 2'b00, 2'd0, 2'd0, FWD,   3'd1};
        vecs[4]  = '{3'b000, 1'b0, 2'b00, 2'd0, 2'd0, STOP,  3'd1};
        vecs[5]  = '{3'b110, 1'b0, 2'b00, 2'd0, 2'd0, FWD,   3'd1};
        vecs[6]  = '{3'b101, 1'b0, 2'b00, 2'd0, 2'd0, RIGHT, 3'd1};
        vecs[7]  = '{3'b011, 1'b1, 2'b01, 2'd1, 2'd2, FWD,   3'd1};
        vecs[8]  = '{3'b010, 1'b1, 2'b11, 2'd1, 2'd0, FWD,   3'd1};
        vecs[9]  = '{3'b010, 1'b1, 2'b10, 2'd1, 2'd0, FWD,   3'd1};
        vecs[10] = '{3'b010, 1'b1, 2'b00, 2'd0, 2'd0, FWD,   3'd1};
        vecs[11] = '{3'b010, 1'b1, 2'b00, 2'd1, 2'd0, FWD,   3'd2};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_aisle = '0; cmd_slot = '0; abort = 1'b0;
        pos_valid = 1'b0; pos_kind = '0; pos_aisle = '0; pos_slot = '0;
        set_lt(3'b010);

        tick(); tick();
        check("rst_state", 8'(state), 8'(3'd0));
        check("rst_mot", 8'(mot), 8'(STOP));
        check("rst_busy", 8'(busy), 8'(1'b0));
        check("rst_done", 8'(done), 8'(1'b0));
        check("rst_err", 8'(err), 8'(1'b0));
        check("rst_ready", 8'(cmd_ready), 8'(1'b0));
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 8'(cmd_ready), 8'(1'b1));

        abort = 1'b1;
        tick();
        check("abort_idle_state", 8'(state), 8'(3'd0));
        abort = 1'b0;

        go(2'd3, 2'd0);
        check("err_aisle", 8'(err), 8'(1'b1));
        check("err_aisle_state", 8'(state), 8'(3'd0));
        check("err_aisle_busy", 8'(busy), 8'(1'b0));
        check("err_done_low", 8'(done), 8'(1'b0));
        tick();
        check("err_one_cycle", 8'(err), 8'(1'b0));
        go(2'd0, 2'd3);
        check("err_slot", 8'(err), 8'(1'b1));
        check("err_slot_ready", 8'(cmd_ready), 8'(1'b1));

        // Full job: aisle 1, slot 2.
        go(2'd1, 2'd2);
        check("job_seek", 8'(state), 8'(3'd1));
        check("job_busy", 8'(busy), 8'(1'b1));
        check("job_ready_low", 8'(cmd_ready), 8'(1'b0));
        check("job_err_low", 8'(err), 8'(1'b0));
        for (int i = 0; i < 12; i++) begin
            set_lt(vecs[i].lt);
            pos_valid = vecs[i].pv;
            pos_kind  = vecs[i].kind;
            pos_aisle = vecs[i].aisle;
            pos_slot  = vecs[i].slot;
            tick();
            pos_valid = 1'b0;
            check($sformatf("seek_vec%0d_mot", i), 8'(mot), 8'(vecs[i].exp_mot));
            check($sformatf("seek_vec%0d_state", i), 8'(state), 8'(vecs[i].exp_st));
        end
        // TURN entered; a slot tag mid-turn must be ignored.
        for (int i = 2; i <= 4; i++) begin
            if (i == 3) begin
                tag(2'b01, 2'd1, 2'd2);
            end else begin
                tick();
            end
            check($sformatf("turn_c%0d_state", i), 8'(state), 8'(3'd2));
            check($sformatf("turn_c%0d_mot", i), 8'(mot), 8'(LEFT));
        end
        tick();
        check("aisle_entry", 8'(state), 8'(3'd3));
        check("aisle_entry_mot", 8'(mot), 8'(LEFT));
        tick();
        check("aisle_follow", 8'(mot), 8'(FWD));
        tag(2'b01, 2'd1, 2'd1);
        check("aisle_wrong_slot", 8'(state), 8'(3'd3));
        tag(2'b11, 2'd0, 2'd0);
        check("aisle_home_ignored", 8'(state), 8'(3'd3));
        tag(2'b01, 2'd0, 2'd2);
        check("aisle_wrong_aisle", 8'(state), 8'(3'd3));
        tag(2'b01, 2'd1, 2'd2);
        check("dwell_entry", 8'(state), 8'(3'd4));
        for (int i = 2; i <= 10; i++) begin
            tick();
            check($sformatf("dwell_c%0d_state", i), 8'(state), 8'(3'd4));
            check($sformatf("dwell_c%0d_mot", i), 8'(mot), 8'(STOP));
        end
        tick();
        check("return_entry", 8'(state), 8'(3'd5));
        set_lt(3'b100);
        tick();
        check("return_follow", 8'(mot), 8'(RIGHT));
        abort = 1'b1;
        tick();
        check("abort_return_state", 8'(state), 8'(3'd5));
        abort = 1'b0;
        tag(2'b11, 2'd0, 2'd0);
        check("home_state", 8'(state), 8'(3'd0));
        check("home_done", 8'(done), 8'(1'b1));
        check("home_err_low", 8'(err), 8'(1'b0));
        check("home_busy", 8'(busy), 8'(1'b0));
        check("home_ready", 8'(cmd_ready), 8'(1'b1));
        tick();
        check("done_one_cycle", 8'(done), 8'(1'b0));
        check("idle_mot", 8'(mot), 8'(STOP));

        // Abort in DWELL cycle 5.
        set_lt(3'b010);
        go(2'd1, 2'd2);
        tag(2'b00, 2'd1, 2'd0);
        for (int i = 0; i < 4; i++) tick();
        tag(2'b01, 2'd1, 2'd2);
        check("abort_dwell_entry", 8'(state), 8'(3'd4));
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_dwell_state", 8'(state), 8'(3'd5));
        tag(2'b11, 2'd0, 2'd0);
        check("abort_dwell_done", 8'(done), 8'(1'b1));

        // Abort beats turn-counter expiry on the last TURN cycle.
        go(2'd2, 2'd0);
        tag(2'b00, 2'd2, 2'd0);
        for (int i = 0; i < 3; i++) tick();
        check("turn_last_cycle", 8'(state), 8'(3'd2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_vs_expiry", 8'(state), 8'(3'd5));
        tag(2'b11, 2'd0, 2'd0);

        // Abort beats a matching junction tag in SEEK.
        go(2'd0, 2'd1);
        abort = 1'b1;
        tag(2'b00, 2'd0, 2'd0);
        abort = 1'b0;
        check("abort_vs_tag", 8'(state), 8'(3'd5));
        tag(2'b11, 2'd0, 2'd0);
        check("abort_vs_tag_home", 8'(state), 8'(3'd0));

        // Reset in TURN cycle 2, then a held command is accepted two cycles later.
        go(2'd1, 2'd2);
        tag(2'b00, 2'd1, 2'd0);
        tick();
        check("pre_rst_turn", 8'(state), 8'(3'd2));
        rst_n = 1'b0;
        tick();
        check("mid_rst_state", 8'(state), 8'(3'd0));
        check("mid_rst_mot", 8'(mot), 8'(STOP));
        check("mid_rst_busy", 8'(busy), 8'(1'b0));
        check("mid_rst_ready", 8'(cmd_ready), 8'(1'b0));
        rst_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_aisle = 2'd0;
        cmd_slot  = 2'd0;
        tick();
        check("post_rst_c1_state", 8'(state), 8'(3'd0));
        check("post_rst_c1_ready", 8'(cmd_ready), 8'(1'b1));
        tick();
        cmd_valid = 1'b0;
        check("post_rst_c2_accept", 8'(state), 8'(3'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
